tag_ram_nway_sync: RTL
======================

Name: tag_ram_nway_sync

Overview:
- Parametrised N-way set-associative tag RAM with per-way valid bits, synchronous read, and a built-in parallel tag compare.
- Successor to the single-way tag RAMs used by the cache controller. Adds hit/way detection, valid tracking, and a hardware invalidate sweep after reset or on flush.
- Sits between the cache controller lookup stage and the data RAM banks.

Parameters:
- AWIDTH, 3, set index width; DEPTH = 2**AWIDTH sets.
- TWIDTH, 9, tag width per way.
- WAYS, 4, associativity; legal values 1, 2, 4, 8.
- WBITS, derived, max(1, log2(WAYS)); way-select width.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_index  in  AWIDTH  lookup set index.
- req_tag  in  TWIDTH  lookup tag to compare.
- wr_en  in  1  write one way of one set.
- wr_index  in  AWIDTH  write set index.
- wr_way  in  WBITS  write way select.
- wr_tag  in  TWIDTH  tag to store.
- wr_vld  in  1  valid bit to store (0 = invalidate that way).
- flush  in  1  single-cycle pulse; start invalidate sweep.
- busy  out  1  sweep in progress; requests and writes ignored.
- resp_valid  out  1  lookup result valid.
- hit  out  1  some valid way matched req_tag.
- hit_way  out  WBITS  lowest matching way.
- resp_tags  out  WAYS*TWIDTH  all stored tags of the set; way w at bits [w*TWIDTH +: TWIDTH].
- resp_vlds  out  WAYS  valid bits of the set.

Behaviour:
- Storage:
  - Tag array has DEPTH x WAYS entries of TWIDTH bits. It is not reset and has no init file.
  - Valid array has DEPTH x WAYS bits. It is cleared only by the sweep.
- State machine has two states, SWEEP and IDLE.
- Reset (rst_n low):
  - State = SWEEP, sweep counter = 0.
  - busy = 1, resp_valid = 0, hit = 0, hit_way = 0.
  - resp_tags = 0, resp_vlds = 0.
- SWEEP:
  - Each cycle clears all WAYS valid bits of set[counter], then increments the counter.
  - When counter == DEPTH-1, that set is cleared and the next state is IDLE. busy falls in the same edge.
  - Total duration is exactly DEPTH cycles after reset release.
  - Reset asserted mid-sweep restarts the sweep from 0.
- IDLE:
  - flush = 1 enters SWEEP with counter = 0 on the next edge. busy = 1 from that edge.
  - flush while busy is ignored; the sweep is not restarted.
- Lookup:
  - Accepted when req_valid & !busy. The index is latched at the edge.
  - One cycle later: resp_valid = 1, resp_tags and resp_vlds reflect the set, and hit/hit_way are computed.
  - hit = OR over ways of (vld[w] & tag[w] == req_tag), using the tag latched with the index.
  - hit_way = lowest w that matches; 0 when hit = 0.
  - resp_valid is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back responses.
  - When resp_valid = 0: hit, hit_way, resp_tags and resp_vlds are forced to 0.
- Write:
  - Applied at the edge when wr_en & !busy: tag[wr_index][wr_way] = wr_tag and vld[wr_index][wr_way] = wr_vld.
  - wr_en while busy is dropped silently.
- Simultaneous write and lookup on the same index in the same cycle: the response shows the newly written data (write-first).
- A lookup accepted in the cycle flush is sampled still responds next cycle. It sees contents before the sweep.
- A write in the same cycle flush is sampled is applied; the sweep then clears its valid bit.
- Width rules: equality compare is the full TWIDTH. wr_way values >= WAYS are ignored (no write).

Test Plan:
- Release rst_n with DEPTH=8 → busy = 1 for exactly 8 cycles, then 0. A lookup of every index returns resp_vlds = 0 and hit = 0.
- Write way 2 of set 5 with tag 0x1A3, vld 1; lookup set 5 with tag 0x1A3 next cycle → resp_valid = 1, hit = 1, hit_way = 2, resp_vlds = 4'b0100.
- Write tag 0x055 to ways 1 and 3 of set 0; lookup 0x055 → hit_way = 1. Write way 1 with vld 0, lookup again → hit_way = 3.
- Same-cycle write of set 3 way 0 with tag 0x0FF and lookup of set 3 with tag 0x0FF → response next cycle shows hit = 1, hit_way = 0.
- Fill sets 0–7, pulse flush → busy high for 8 cycles; requests and writes during that time give resp_valid = 0 and no effect. Afterwards all lookups miss.
- Assert rst_n low at sweep cycle 4 for 2 cycles → after release the sweep restarts and busy stays high for a full 8 cycles.

Source files
------------

// File: rtl/tag_ram_nway_sync.sv
// N-way set-associative tag RAM with per-way valid bits and a parallel tag compare.
// Latency: a lookup accepted at edge k responds right after edge k (one cycle, registered outputs).
// Backpressure: none; requests and writes that arrive while busy is high are dropped.
//
// Ports:
//   clock, rst_n                - rising-edge clock, asynchronous active-low reset
//   req_valid/req_index/req_tag - lookup request (set index and tag to compare)
//   wr_en/wr_index/wr_way/
//   wr_tag/wr_vld               - write one way of one set (wr_vld=0 invalidates that way)
//   flush                       - one-cycle pulse that starts a full invalidate sweep
//   busy                        - sweep in progress
//   resp_valid/hit/hit_way/
//   resp_tags/resp_vlds         - lookup response; all zero whenever resp_valid is low
module tag_ram_nway_sync #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 9,
    parameter int WAYS   = 4,
    localparam int WBITS = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int DEPTH = 2 ** AWIDTH
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [AWIDTH-1:0]        req_index,
    input  logic [TWIDTH-1:0]        req_tag,
    input  logic                     wr_en,
    input  logic [AWIDTH-1:0]        wr_index,
    input  logic [WBITS-1:0]         wr_way,
    input  logic [TWIDTH-1:0]        wr_tag,
    input  logic                     wr_vld,
    input  logic                     flush,
    output logic                     busy,
    output logic                     resp_valid,
    output logic                     hit,
    output logic [WBITS-1:0]         hit_way,
    output logic [WAYS*TWIDTH-1:0]   resp_tags,
    output logic [WAYS-1:0]          resp_vlds
);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Storage. The tag array is never reset: a way is only meaningful
    // while its valid bit is set, and valid bits are cleared by the sweep.
    // ------------------------------------------------------------------
    logic [TWIDTH-1:0] tag_mem [DEPTH][WAYS];
    logic [WAYS-1:0]   vld_mem [DEPTH];

    // Sweep state machine.
    state_e            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic              busy_q;

    // Registered response.
    logic                   resp_valid_q;
    logic                   hit_q,       hit_d;
    logic [WBITS-1:0]       hit_way_q,   hit_way_d;
    logic [WAYS*TWIDTH-1:0] resp_tags_q, resp_tags_d;
    logic [WAYS-1:0]        resp_vlds_q, resp_vlds_d;

    logic            accept;
    logic            wr_go;
    logic [WAYS-1:0] wr_sel;
    logic            same_set;

    assign accept   = req_valid & ~busy_q;
    assign wr_go    = wr_en & ~busy_q;
    assign same_set = (wr_index == req_index);

    // One-hot way decode. Way numbers at or above WAYS select nothing,
    // so an out-of-range wr_way leaves the array untouched.
    always_comb begin
        wr_sel = '0;
        for (int w = 0; w < WAYS; w++) begin
            wr_sel[w] = wr_go && (int'(wr_way) == w);
        end
    end

    // ------------------------------------------------------------------
    // Set read with write-first bypass: a write to the looked-up set in
    // the same cycle is visible in the response.
    // ------------------------------------------------------------------
    always_comb begin
        resp_tags_d = '0;
        resp_vlds_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (wr_sel[w] && same_set) begin
                resp_tags_d[w*TWIDTH +: TWIDTH] = wr_tag;
                resp_vlds_d[w]                  = wr_vld;
            end else begin
                resp_tags_d[w*TWIDTH +: TWIDTH] = tag_mem[req_index][w];
                resp_vlds_d[w]                  = vld_mem[req_index][w];
            end
        end
    end

    // Parallel compare. Scanning from the top way down lets the lowest
    // matching way overwrite any higher one, giving lowest-way priority.
    always_comb begin
        hit_d     = 1'b0;
        hit_way_d = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (resp_vlds_d[w] && (resp_tags_d[w*TWIDTH +: TWIDTH] == req_tag)) begin
                hit_d     = 1'b1;
                hit_way_d = WBITS'(w);
            end
        end
    end

    // ------------------------------------------------------------------
    // Array updates. Writes are already gated off while sweeping, so the
    // sweep and a write can never target the valid array in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_sel[w]) begin
                tag_mem[wr_index][w] <= wr_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (busy_q) begin
            vld_mem[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (wr_sel[w]) begin
                    vld_mem[wr_index][w] <= wr_vld;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM. busy is registered alongside the state so it rises on
    // the flush edge and falls on the edge that clears the last set.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                SWEEP: begin
                    if (cnt_q == AWIDTH'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (flush) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SWEEP;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response register. Everything is zeroed on cycles without a response
    // so downstream logic can OR or sample the bus without qualifying it.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            resp_tags_q  <= '0;
            resp_vlds_q  <= '0;
        end else begin
            resp_valid_q <= accept;
            hit_q        <= accept ? hit_d       : 1'b0;
            hit_way_q    <= accept ? hit_way_d   : '0;
            resp_tags_q  <= accept ? resp_tags_d : '0;
            resp_vlds_q  <= accept ? resp_vlds_d : '0;
        end
    end

    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign resp_tags  = resp_tags_q;
    assign resp_vlds  = resp_vlds_q;

endmodule
